// File: rtl/iir_pkg.sv
// iir_pkg: widths and transmitter state encoding shared by the IIR output path
package iir_pkg;
    localparam int DATA_W     = 10;
    localparam int FRAME_BITS = 13;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/iir_sample_fifo.sv
// iir_sample_fifo: circular sample buffer with occupancy count
module iir_sample_fifo #(
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic                              pop,
    input  logic [DATA_W-1:0]                 din,
    output logic [DATA_W-1:0]                 dout,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;
    assign full  = count_q == CW'(FIFO_DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign dout  = mem_q[rd_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d    = do_push ? (wr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d    = do_pop  ? (rd_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/iir_uart_tx.sv
// iir_uart_tx: buffers filtered samples and serialises them as start/data/even-parity/stop frames
module iir_uart_tx
    import iir_pkg::*;
#(
    parameter int DATA_W       = iir_pkg::DATA_W,
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] y_in,
    input  logic              y_valid,
    output logic              y_ready,
    output logic              tx,
    output logic              busy,
    output logic              overflow
);
    localparam int BW   = $clog2(CLKS_PER_BIT);
    localparam int BITW = $clog2(DATA_W);
    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, dout;
    logic [BW-1:0]     baud_q, baud_d;
    logic [BITW-1:0]   bit_q, bit_d;
    logic              parity_q, parity_d, tx_q, tx_d, overflow_q, overflow_d;
    logic              full, empty, pop, baud_end;
    logic [$clog2(FIFO_DEPTH+1)-1:0] count;
    iir_sample_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(y_valid), .pop(pop), .din(y_in),
        .dout(dout), .full(full), .empty(empty), .count(count)
    );
    assign baud_end = baud_q == BW'(CLKS_PER_BIT - 1);
    // STOP pops at its last cycle so queued samples follow with no idle gap
    assign pop      = (state_q == IDLE || (state_q == STOP && baud_end)) && !empty;
    assign y_ready  = !full;
    assign busy     = state_q != IDLE || count != '0;
    assign tx       = tx_q;
    assign overflow = overflow_q;
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        bit_d      = bit_q;
        baud_d     = (state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
        overflow_d = overflow_q | (y_valid & full);
        case (state_q)
            START:  if (baud_end) state_d = DATA;
            DATA:   if (baud_end) begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BITW'(DATA_W - 1)) begin
                            state_d = PARITY;
                            bit_d   = '0;
                        end
                    end
            PARITY: if (baud_end) state_d = STOP;
            STOP:   if (baud_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (pop) begin
            state_d  = START;
            shift_d  = dout;
            parity_d = ^dout;
            bit_d    = '0;
            baud_d   = '0;
        end
        // tx is registered from the next state so the line changes on the state edge itself
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? parity_d : 1'b1;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            baud_q     <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_iir_uart_tx.sv
// tb_iir_uart_tx: directed stimulus with a frame-decoding monitor checking against a sample scoreboard
module tb_iir_uart_tx;
    import iir_pkg::*;
    localparam int CPB   = 4;
    localparam int DEPTH = 2;
    localparam int FLEN  = FRAME_BITS * CPB;
    logic              clk = 1'b0, reset = 1'b0, y_valid = 1'b0;
    logic [DATA_W-1:0] y_in = '0;
    logic              y_ready, tx, busy, overflow;
    int                total = 0, bad = 0, cyc = 0;
    logic [DATA_W-1:0] sb [$];
    int                starts [$];
    logic [FRAME_BITS-1:0] last_mb = '0;
    iir_uart_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .y_in(y_in), .y_valid(y_valid),
        .y_ready(y_ready), .tx(tx), .busy(busy), .overflow(overflow)
    );
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // monitor: decodes every frame on tx at bit centres and checks it against the scoreboard head
    initial begin
        int mpos;
        logic mact;
        logic [FRAME_BITS-1:0] mb;
        logic [DATA_W-1:0] e;
        mact = 1'b0;
        mpos = 0;
        mb   = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) mact = 1'b0;
            else begin
                if (!mact && tx === 1'b0) begin
                    mact = 1'b1;
                    mpos = 0;
                    starts.push_back(cyc);
                end else if (mact) mpos++;
                if (mact && mpos % CPB == CPB / 2) mb[mpos / CPB] = tx;
                if (mact && mpos == FLEN - 1) begin
                    mact    = 1'b0;
                    last_mb = mb;
                    if (sb.size() == 0) chk("unexpected_frame", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("frame_start", mb[0], 0);
                        chk("frame_data", mb[DATA_W:1], e);
                        chk("frame_parity", mb[DATA_W+1], ^e);
                        chk("frame_stop", mb[FRAME_BITS-1], 1);
                    end
                end
            end
        end
    end
    task automatic push(input logic [DATA_W-1:0] v, input bit acc);
        y_in    = v;
        y_valid = 1'b1;
        if (acc) sb.push_back(v);
        @(posedge clk);
        #1 y_valid = 1'b0;
    endtask
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", busy, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask
    initial begin
        int low, nf, s;
        logic [11:0] t2;
        logic [DATA_W-1:0] v4 [4];
        // 1: reset and idle line
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", y_ready, 1);
        chk("rst_ovf", overflow, 0);
        low = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) low++;
        end
        chk("idle_tx_low_cycles", low, 0);
        // 2: single sample 0x1FC, latency, explicit bit pattern and busy length
        push(10'h1FC, 1);
        chk("t2_tx_edge_n", tx, 1);
        @(posedge clk);
        #1 chk("t2_tx_edge_n1", tx, 0);
        t2 = 12'b11_0111111100;
        repeat (6) @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            #1 chk($sformatf("t2_bit%0d", k), tx, t2[k]);
            if (k < 11) repeat (4) @(posedge clk);
        end
        @(posedge clk);
        #1 chk("t2_busy_last", busy, 1);
        @(posedge clk);
        #1 chk("t2_busy_fall", busy, 0);
        wait_idle();
        // 3: all-ones and all-zeros frames both carry parity 0
        push(10'h3FF, 1);
        wait_idle();
        chk("t3_ff_data", last_mb[DATA_W:1], 10'h3FF);
        chk("t3_ff_parity", last_mb[DATA_W+1], 0);
        push(10'h000, 1);
        wait_idle();
        chk("t3_00_data", last_mb[DATA_W:1], 10'h000);
        chk("t3_00_parity", last_mb[DATA_W+1], 0);
        // 4: four consecutive pushes, fourth dropped, three frames back to back
        v4[0] = 10'h2A5; v4[1] = 10'h0F0; v4[2] = 10'h301; v4[3] = 10'h155;
        y_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            y_in = v4[i];
            if (i < 3) sb.push_back(v4[i]);
            @(posedge clk);
            #1;
        end
        y_valid = 1'b0;
        chk("t4_overflow", overflow, 1);
        chk("t4_ready", y_ready, 0);
        wait_idle();
        s = starts.size();
        chk("t4_gap12", starts[s-2] - starts[s-3], FLEN);
        chk("t4_gap23", starts[s-1] - starts[s-2], FLEN);
        chk("t4_ovf_sticky", overflow, 1);
        // 5: reset during data bit 5 aborts the frame
        push(10'h155, 1);
        repeat (26) @(posedge clk);
        @(negedge clk);
        chk("t5_tx_bit5", tx, 0);
        reset = 1'b0;
        #1;
        chk("t5_tx_rst", tx, 1);
        chk("t5_busy_rst", busy, 0);
        chk("t5_ovf_rst", overflow, 0);
        chk("t5_ready_rst", y_ready, 1);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        nf = starts.size();
        repeat (80) @(negedge clk);
        chk("t5_no_remnant", starts.size(), nf);
        chk("t5_idle_tx", tx, 1);
        // 6: impulse response of the filter paced once per 60 cycles
        @(posedge clk);
        #1;
        for (int k = 0; k < 20; k++) begin
            push(k < 10 ? DATA_W'(508 >> k) : '0, 1);
            repeat (59) @(posedge clk);
            #1;
        end
        wait_idle();
        chk("t6_no_overflow", overflow, 0);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iir_uart_tx.md
Name: iir_uart_tx

Overview:
- Downstream stage of the IIR filter. Takes each 10-bit filtered sample `y` and sends it off-chip on a single pin as a UART-style frame.
- A 2-entry sample FIFO absorbs back-to-back samples while a frame is in flight.
- Frame format: start bit, 10 data bits LSB first, even parity bit, stop bit.
- Lets the filter output be observed on one I/O pin instead of ten.

Parameters:
- DATA_W, 10: sample width; matches the IIR output width.
- CLKS_PER_BIT, 4: clk cycles each serial bit is held; legal range ≥ 2.
- FIFO_DEPTH, 2: sample buffer entries; must be ≥ 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- y_in  input  DATA_W  filtered sample from the IIR stage.
- y_valid  input  1  y_in is a new sample this cycle.
- y_ready  output  1  FIFO can accept a sample (count != FIFO_DEPTH).
- tx  output  1  serial line, registered; idles at 1.
- busy  output  1  frame in progress or FIFO non-empty.
- overflow  output  1  sticky flag: a sample was dropped while the FIFO was full.

Behaviour:
Reset (reset = 0, asynchronous):
- tx = 1, busy = 0, overflow = 0, y_ready = 1.
- FIFO emptied, FSM returns to IDLE, bit and baud counters = 0.
- Asserting reset mid-frame aborts the frame immediately; tx returns to 1 with no glitch to 0.

Push rules:
- A sample is pushed on a rising edge when y_valid = 1 and count < FIFO_DEPTH.
- If y_valid = 1 while full, the sample is dropped and overflow is set.
- This holds even if a pop occurs in the same cycle: y_ready is decoded from the current count only.
- overflow clears only on reset.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if FIFO non-empty at an edge, pop the head into the shift register, compute parity = XOR of the 10 data bits, and go to START.
  - tx = 0 from that edge.
  - Latency: a sample pushed at edge n into an empty FIFO in IDLE drives tx low from edge n+1.
- START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx = shift[0], one bit per CLKS_PER_BIT cycles, 10 bits LSB first; after bit 9 go to PARITY.
- PARITY: tx = parity for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx = 1 for CLKS_PER_BIT cycles. At the final edge:
  - if the FIFO is non-empty, pop and go straight to START (no idle gap);
  - otherwise go to IDLE.

Frame length: exactly 13 × CLKS_PER_BIT cycles.

Status outputs:
- busy = (state != IDLE) || (count != 0).
- Same-cycle push and pop with count < FIFO_DEPTH: count is unchanged, FIFO order is preserved.

Counters:
- Baud counter runs 0 .. CLKS_PER_BIT−1 and is cleared on each state or bit change.
- Bit counter runs 0..9 and is used only in DATA.

Decomposition:
- Shared package iir_pkg holds:
  - localparams DATA_W = 10 and FRAME_BITS = 13;
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
- The IIR filter and bench import DATA_W from the same package.
- One sub-module: iir_sample_fifo.
  - Parameterised by DATA_W and FIFO_DEPTH; circular buffer with a count.
  - Ports: push, pop, din, dout, full, empty, count; same async active-low reset.

Test Plan (CLKS_PER_BIT = 4, FIFO_DEPTH = 2):
1. Hold reset = 0 for 3 cycles, then release → tx = 1, busy = 0, y_ready = 1, overflow = 0; tx remains 1 for 20 idle cycles.
2. Single push y_in = 10'h1FC at edge n → tx low on edges n+1..n+4, then data bits 0,0,1,1,1,1,1,1,1,0 each held 4 cycles, parity = 1, stop = 1. busy falls 52 cycles after edge n+1.
3. Push 10'h3FF, then later 10'h000 → both frames carry parity bit 0; the 10'h3FF data field is all 1s.
4. Push on 4 consecutive edges n..n+3 → the first 3 are accepted (pop at n+1 frees a slot), the 4th is dropped. overflow = 1 and y_ready = 0 after edge n+3. Three frames go out back-to-back over 156 cycles with no idle cycle between them.
5. Assert reset during DATA bit 5 of a frame → tx = 1 immediately (before the next edge), busy = 0, overflow = 0. After release, no remnant bits are transmitted.
6. Drive 20 impulse-response samples from the IIR stage (x = 127 then 0) with y_valid pulsed once per 60 cycles → the decoded serial stream equals 508, 254, 127, 63, 31, … with no overflow.
